// File: rtl/axi_ram_slave.sv
// AXI3 slave RAM: one write burst and one read burst in flight at a time, each
// with its own FSM. Optional LFSR-driven stalls exercise master backpressure.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting write beats until the captured length is reached
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | read latency countdown before the first beat is launched
// R_DATA | presenting read beats until the rlast handshake
module axi_ram_slave #(
    parameter int          DATA_WIDTH = 64,
    parameter int          ID_WIDTH   = 6,
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          RD_LATENCY = 2,
    parameter int          STALL_EN   = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     m_axi_awid,
    input  logic [31:0]             m_axi_awaddr,
    input  logic [3:0]              m_axi_awlen,
    input  logic                    m_axi_awvalid,
    output logic                    m_axi_awready,
    input  logic [DATA_WIDTH-1:0]   m_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    input  logic                    m_axi_wlast,
    input  logic                    m_axi_wvalid,
    output logic                    m_axi_wready,
    output logic [ID_WIDTH-1:0]     m_axi_bid,
    output logic [1:0]              m_axi_bresp,
    output logic                    m_axi_bvalid,
    input  logic                    m_axi_bready,
    input  logic [ID_WIDTH-1:0]     m_axi_arid,
    input  logic [31:0]             m_axi_araddr,
    input  logic [3:0]              m_axi_arlen,
    input  logic                    m_axi_arvalid,
    output logic                    m_axi_arready,
    output logic [DATA_WIDTH-1:0]   m_axi_rdata,
    output logic [ID_WIDTH-1:0]     m_axi_rrid,
    output logic [1:0]              m_axi_rresp,
    output logic                    m_axi_rlast,
    output logic                    m_axi_rvalid,
    input  logic                    m_axi_rready
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam logic [63:0] WIN_BYTES = 64'(STRB_W) << DEPTH_LOG2;
    // Counter only needs to hold RD_LATENCY-1.
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE_ADDR) && (({32'd0, a} - {32'd0, BASE_ADDR}) < WIN_BYTES);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> BYTE_SH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [15:0] lfsr_q, lfsr_d;
    logic        run_q;
    logic        stall;

    wstate_t               wst_q, wst_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d;
    logic [3:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                  wwin_q, wwin_d, werr_q, werr_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_hs, w_mis, mem_we;

    rstate_t               rst_q, rst_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;
    logic [3:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                  rwin_q, rwin_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  launch;

    // Galois LFSR next value and the stall it produces.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    assign stall = (STALL_EN != 0) && (lfsr_q[1:0] == 2'b00);

    // run_q keeps every ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            run_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            run_q  <= 1'b1;
        end
    end

    assign m_axi_awready = run_q && !stall && (wst_q == W_IDLE);
    assign m_axi_wready  = run_q && !stall && (wst_q == W_DATA);
    assign m_axi_bvalid  = (wst_q == W_RESP);
    assign m_axi_bid     = bid_q;
    assign m_axi_bresp   = bresp_q;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign w_mis  = m_axi_wlast != (wcnt_q == wlen_q);
    assign mem_we = w_hs && wwin_q;

    // Write FSM next state; the burst length always follows awlen, wlast only grades the response.
    always_comb begin
        wst_d   = wst_q;
        bid_d   = bid_q;
        widx_d  = widx_q;
        wlen_d  = wlen_q;
        wcnt_d  = wcnt_q;
        wwin_d  = wwin_q;
        werr_d  = werr_q;
        bresp_d = bresp_q;
        case (wst_q)
            W_IDLE: if (m_axi_awvalid && m_axi_awready) begin
                bid_d  = m_axi_awid;
                widx_d = word_idx(m_axi_awaddr);
                wlen_d = m_axi_awlen;
                wcnt_d = 4'd0;
                wwin_d = in_window(m_axi_awaddr);
                werr_d = 1'b0;
                wst_d  = W_DATA;
            end
            W_DATA: if (w_hs) begin
                widx_d = widx_q + DEPTH_LOG2'(1);
                wcnt_d = wcnt_q + 4'd1;
                werr_d = werr_q | w_mis;
                if (wcnt_q == wlen_q) begin
                    wst_d   = W_RESP;
                    bresp_d = !wwin_q ? 2'b11 : ((werr_q | w_mis) ? 2'b10 : 2'b00);
                end
            end
            W_RESP: if (m_axi_bready) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q   <= W_IDLE;
            bid_q   <= '0;
            widx_q  <= '0;
            wlen_q  <= '0;
            wcnt_q  <= '0;
            wwin_q  <= 1'b0;
            werr_q  <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            wst_q   <= wst_d;
            bid_q   <= bid_d;
            widx_q  <= widx_d;
            wlen_q  <= wlen_d;
            wcnt_q  <= wcnt_d;
            wwin_q  <= wwin_d;
            werr_q  <= werr_d;
            bresp_q <= bresp_d;
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (m_axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= m_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign m_axi_arready = run_q && !stall && (rst_q == R_IDLE);
    assign m_axi_rvalid  = rvalid_q;
    assign m_axi_rlast   = rlast_q;
    assign m_axi_rresp   = rresp_q;
    assign m_axi_rrid    = rid_q;
    assign m_axi_rdata   = rdata_q;

    // Read FSM next state; a beat is only launched into an empty or just-accepted output slot.
    always_comb begin
        rst_d    = rst_q;
        rid_d    = rid_q;
        ridx_d   = ridx_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rwin_d   = rwin_q;
        lat_d    = lat_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rresp_d  = rresp_q;
        launch   = 1'b0;
        case (rst_q)
            R_IDLE: if (m_axi_arvalid && m_axi_arready) begin
                rid_d  = m_axi_arid;
                ridx_d = word_idx(m_axi_araddr);
                rlen_d = m_axi_arlen;
                rcnt_d = 4'd0;
                rwin_d = in_window(m_axi_araddr);
                lat_d  = LAT_LOAD;
                rst_d  = R_WAIT;
            end
            R_WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                end else if (!stall) begin
                    launch = 1'b1;
                    rst_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && m_axi_rready && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    rst_d    = R_IDLE;
                end else if (!rvalid_q || m_axi_rready) begin
                    if (!stall) launch = 1'b1;
                    else        rvalid_d = 1'b0;
                end
            end
            default: rst_d = R_IDLE;
        endcase
        if (launch) begin
            rvalid_d = 1'b1;
            rlast_d  = (rcnt_q == rlen_q);
            rresp_d  = rwin_q ? 2'b00 : 2'b11;
            ridx_d   = ridx_q + DEPTH_LOG2'(1);
            rcnt_d   = rcnt_q + 4'd1;
        end
    end

    // Read FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q    <= R_IDLE;
            rid_q    <= '0;
            ridx_q   <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rwin_q   <= 1'b0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= 2'b00;
        end else begin
            rst_q    <= rst_d;
            rid_q    <= rid_d;
            ridx_q   <= ridx_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rwin_q   <= rwin_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rresp_q  <= rresp_d;
        end
    end

    // Read data register; sampling mem here makes a same-edge write read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rdata_q <= '0;
        else if (launch) rdata_q <= rwin_q ? mem[ridx_q] : '0;
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: instance 0 without stalls, instance 1 with LFSR stalls.
module tb_axi_ram_slave;
    localparam int DW = 64, IW = 6, DL = 8, LIM = 500;
    localparam logic [31:0] BASE = 32'h2000_0000;

    typedef struct { int d; logic [63:0] data; logic [1:0] resp; logic [IW-1:0] id; logic last; } r_exp_t;
    typedef struct { int d; logic [1:0] resp; logic [IW-1:0] id; } b_exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [IW-1:0] awid[2], bid[2], arid[2], rrid[2];
    logic [31:0]   awaddr[2], araddr[2];
    logic [3:0]    awlen[2], arlen[2];
    logic [DW-1:0] wdata[2], rdata[2];
    logic [7:0]    wstrb[2];
    logic [1:0]    bresp[2], rresp[2];
    logic awvalid[2], awready[2], wlast[2], wvalid[2], wready[2], bvalid[2], bready[2];
    logic arvalid[2], arready[2], rlast[2], rvalid[2], rready[2];

    int checks = 0, failures = 0, rr_cnt = 0;
    r_exp_t rq[$];
    b_exp_t bq[$];
    logic [63:0] wbuf[16], ebuf[16];
    logic pend[2];
    logic [DW-1:0] save_d[2];
    logic [IW+2:0] save_c[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_ram_slave #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH_LOG2(DL), .BASE_ADDR(BASE),
                        .RD_LATENCY(2), .STALL_EN(g), .LFSR_SEED(16'hACE1)) u_dut (
            .clk(clk), .rst(rst),
            .m_axi_awid(awid[g]), .m_axi_awaddr(awaddr[g]), .m_axi_awlen(awlen[g]),
            .m_axi_awvalid(awvalid[g]), .m_axi_awready(awready[g]),
            .m_axi_wdata(wdata[g]), .m_axi_wstrb(wstrb[g]), .m_axi_wlast(wlast[g]),
            .m_axi_wvalid(wvalid[g]), .m_axi_wready(wready[g]),
            .m_axi_bid(bid[g]), .m_axi_bresp(bresp[g]), .m_axi_bvalid(bvalid[g]), .m_axi_bready(bready[g]),
            .m_axi_arid(arid[g]), .m_axi_araddr(araddr[g]), .m_axi_arlen(arlen[g]),
            .m_axi_arvalid(arvalid[g]), .m_axi_arready(arready[g]),
            .m_axi_rdata(rdata[g]), .m_axi_rrid(rrid[g]), .m_axi_rresp(rresp[g]),
            .m_axi_rlast(rlast[g]), .m_axi_rvalid(rvalid[g]), .m_axi_rready(rready[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout_or_extra required=handshake", nm);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_awready", awready[d], 0);
        chk("rst_wready",  wready[d], 0);
        chk("rst_arready", arready[d], 0);
        chk("rst_bvalid",  bvalid[d], 0);
        chk("rst_rvalid",  rvalid[d], 0);
        chk("rst_rlast",   rlast[d], 0);
        chk("rst_resp",    {bresp[d], rresp[d]}, 0);
        chk("rst_ids",     {bid[d], rrid[d]}, 0);
        chk("rst_rdata",   rdata[d], 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) fail("drain");
        @(posedge clk); #1;
    endtask

    task automatic wr(input int d, input logic [31:0] addr, input int len, input logic [IW-1:0] id,
                      input logic [7:0] strb, input int wl_beat, input logic [1:0] exp_resp, input bit lat);
        int n;
        bq.push_back('{d, exp_resp, id});
        awvalid[d] = 1'b1; awaddr[d] = addr; awlen[d] = 4'(len); awid[d] = id;
        n = 0; @(negedge clk);
        while (!awready[d] && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) fail("aw_wait");
        @(posedge clk); #1 awvalid[d] = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid[d] = 1'b1; wdata[d] = wbuf[i]; wstrb[d] = strb; wlast[d] = (i == wl_beat);
            n = 0; @(negedge clk);
            while (!wready[d] && n < LIM) begin @(negedge clk); n++; end
            if (n >= LIM) fail("w_wait");
            if (lat && i == 0) chk("aw_to_wready", n, 0);
            @(posedge clk); #1;
        end
        wvalid[d] = 1'b0; wlast[d] = 1'b0;
        if (lat) begin
            n = 1; @(negedge clk);
            while (!bvalid[d] && n < LIM) begin @(negedge clk); n++; end
            chk("wlast_to_bvalid", n, 1);
        end
        drain();
    endtask

    task automatic rd(input int d, input logic [31:0] addr, input int len, input logic [IW-1:0] id,
                      input logic [1:0] resp, input bit lat);
        int n;
        for (int i = 0; i <= len; i++)
            rq.push_back('{d, (resp == 2'b11) ? 64'd0 : ebuf[i], resp, id, (i == len)});
        arvalid[d] = 1'b1; araddr[d] = addr; arlen[d] = 4'(len); arid[d] = id;
        n = 0; @(negedge clk);
        while (!arready[d] && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) fail("ar_wait");
        @(posedge clk); #1 arvalid[d] = 1'b0;
        if (lat) begin
            n = 1; @(negedge clk);
            while (!rvalid[d] && n < LIM) begin @(negedge clk); n++; end
            chk("ar_to_rvalid", n, 3);
        end
        drain();
    endtask

    // Monitor: pops the scoreboard on every R/B handshake and checks beats held under backpressure.
    initial begin
        r_exp_t re;
        b_exp_t be;
        pend[0] = 1'b0; pend[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend[0] = 1'b0; pend[1] = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (pend[d]) begin
                        chk("r_hold_valid", rvalid[d], 1);
                        chk("r_hold_data", rdata[d], save_d[d]);
                        chk("r_hold_ctl", {rrid[d], rresp[d], rlast[d]}, save_c[d]);
                    end
                    pend[d] = rvalid[d] && !rready[d];
                    save_d[d] = rdata[d];
                    save_c[d] = {rrid[d], rresp[d], rlast[d]};
                    if (rvalid[d] && rready[d]) begin
                        if (rq.size() == 0) fail("r_unexpected");
                        else begin
                            re = rq.pop_front();
                            chk("r_port", d, re.d);
                            chk("rdata", rdata[d], re.data);
                            chk("rresp", rresp[d], re.resp);
                            chk("rrid", rrid[d], re.id);
                            chk("rlast", rlast[d], re.last);
                        end
                    end
                    if (bvalid[d] && bready[d]) begin
                        if (bq.size() == 0) fail("b_unexpected");
                        else begin
                            be = bq.pop_front();
                            chk("b_port", d, be.d);
                            chk("bresp", bresp[d], be.resp);
                            chk("bid", bid[d], be.id);
                        end
                    end
                end
            end
        end
    end

    // Instance 1 sees rready low one cycle in three.
    initial begin
        rready[1] = 1'b0;
        forever begin
            @(posedge clk); #1;
            rr_cnt++;
            rready[1] = (rr_cnt % 3) != 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            awvalid[d] = 0; awid[d] = 0; awaddr[d] = 0; awlen[d] = 0;
            wvalid[d] = 0; wdata[d] = 0; wstrb[d] = 0; wlast[d] = 0; bready[d] = 1;
            arvalid[d] = 0; arid[d] = 0; araddr[d] = 0; arlen[d] = 0;
        end
        rready[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", awready[0], 0);
        @(negedge clk);
        chk("ready_after_edge", {awready[0], arready[0], wready[0]}, 3'b110);
        @(posedge clk); #1;

        // Basic 4-beat write and read-back with latency checks.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); ebuf[i] = 64'(i + 1); end
        wr(0, BASE, 3, 6'd5, 8'hFF, 3, 2'b00, 1'b1);
        rd(0, BASE, 3, 6'd9, 2'b00, 1'b1);

        // Byte strobes.
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(0, BASE + 32'h100, 0, 6'd1, 8'hFF, 0, 2'b00, 1'b0);
        wbuf[0] = 64'd0;
        wr(0, BASE + 32'h100, 0, 6'd1, 8'h0F, 0, 2'b00, 1'b0);
        ebuf[0] = 64'hFFFF_FFFF_0000_0000;
        rd(0, BASE + 32'h100, 0, 6'd2, 2'b00, 1'b0);

        // Same-edge read launch and write beat on word 1 (holds 2): read-first.
        rq.push_back('{0, 64'd2, 2'b00, 6'd3, 1'b1});
        bq.push_back('{0, 2'b00, 6'd4});
        arvalid[0] = 1; araddr[0] = BASE + 32'h8; arlen[0] = 0; arid[0] = 6'd3;
        @(posedge clk); #1 arvalid[0] = 0;
        awvalid[0] = 1; awaddr[0] = BASE + 32'h8; awlen[0] = 0; awid[0] = 6'd4;
        @(posedge clk); #1 awvalid[0] = 0;
        wvalid[0] = 1; wdata[0] = 64'h55; wstrb[0] = 8'hFF; wlast[0] = 1;
        @(posedge clk); #1 wvalid[0] = 0; wlast[0] = 0;
        drain();
        ebuf[0] = 64'h55;
        rd(0, BASE + 32'hC, 0, 6'd7, 2'b00, 1'b0);

        // Window edges and index wrap.
        rd(0, 32'h1FFF_FFF8, 0, 6'd2, 2'b11, 1'b0);
        rd(0, BASE + 32'h800, 1, 6'd3, 2'b11, 1'b0);
        wbuf[0] = 64'hDEAD;
        wr(0, 32'h1FFF_FFF8, 0, 6'd6, 8'hFF, 0, 2'b11, 1'b0);
        wbuf[0] = 64'hA0A0; wbuf[1] = 64'hB1B1;
        wr(0, BASE + 32'h7F8, 1, 6'd8, 8'hFF, 1, 2'b00, 1'b0);
        ebuf[0] = 64'hB1B1;
        rd(0, BASE, 0, 6'd9, 2'b00, 1'b0);
        ebuf[0] = 64'hA0A0; ebuf[1] = 64'hB1B1;
        rd(0, BASE + 32'h7F8, 1, 6'd10, 2'b00, 1'b0);

        // wlast errors: early and missing.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(8'h11 + i); ebuf[i] = 64'(8'h11 + i); end
        wr(0, BASE + 32'h200, 3, 6'd12, 8'hFF, 1, 2'b10, 1'b0);
        rd(0, BASE + 32'h200, 3, 6'd13, 2'b00, 1'b0);
        wr(0, BASE + 32'h280, 0, 6'd14, 8'hFF, -1, 2'b10, 1'b0);

        // Backpressure on the stalling instance.
        for (int i = 0; i < 16; i++) begin wbuf[i] = 64'h0F00 + 64'(i); ebuf[i] = 64'h0F00 + 64'(i); end
        wr(1, BASE + 32'h400, 15, 6'd20, 8'hFF, 15, 2'b00, 1'b0);
        rd(1, BASE + 32'h400, 15, 6'h2A, 2'b00, 1'b0);

        // Reset during the second beat of an 8-beat write.
        awvalid[0] = 1; awaddr[0] = BASE + 32'h300; awlen[0] = 7; awid[0] = 6'd1;
        @(posedge clk); #1 awvalid[0] = 0;
        wvalid[0] = 1; wdata[0] = 64'h100; wstrb[0] = 8'hFF; wlast[0] = 0;
        @(posedge clk); #1 wdata[0] = 64'h101;
        #2 rst = 1'b1;
        #1 chk_reset(0);
        wvalid[0] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        ebuf[0] = 64'h100;
        rd(0, BASE + 32'h300, 0, 6'd2, 2'b00, 1'b0);
        wbuf[0] = 64'h200; wbuf[1] = 64'h201; ebuf[0] = 64'h200; ebuf[1] = 64'h201;
        wr(0, BASE + 32'h300, 1, 6'd3, 8'hFF, 1, 2'b00, 1'b1);
        rd(0, BASE + 32'h300, 1, 6'd4, 2'b00, 1'b1);

        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
